// File: rtl/axi_slave_mem.sv
// ---------------------------------------------------------------------------
// axi_slave_mem
//   AXI3-style slave memory serving the AW/W/AR/R channels of the burst
//   master (no B channel). Write bursts land in an internal word array and
//   read bursts are returned from it. The write and read FSMs are independent
//   and may run concurrently.
//
// Parameters
//   DATA_WIDTH    data bus width, one memory word per beat
//   ADRESS_WIDTH  byte address width
//   MEM_DEPTH     number of words (power of 2)
//
// Ports
//   ACLK, ARESETn                      clock / async active-low reset
//   AWADDR AWLEN AWSIZE AWBURST        write address channel payload
//   AWVALID / AWREADY                  write address handshake
//   WDATA WLAST, WVALID / WREADY       write data channel
//   ARADDR ARLEN ARSIZE ARBURST        read address channel payload
//   ARVALID / ARREADY                  read address handshake
//   RDATA RLAST, RVALID / RREADY       read data channel
//   wlast_err                          sticky: WLAST disagreed with beat count
//
// Build option
//   AXI_SLV_WAIT_EN  when defined, WREADY drops for one cycle after every
//                    accepted write beat (at most one beat per two cycles).
// ---------------------------------------------------------------------------
module axi_slave_mem #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADRESS_WIDTH = 32,
  parameter int MEM_DEPTH    = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ADRESS_WIDTH-1:0] AWADDR,
  input  logic [3:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  input  logic [ADRESS_WIDTH-1:0] ARADDR,
  input  logic [3:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic                    wlast_err
);

  localparam int         IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [2:0] SZ_MAX = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic {W_IDLE, W_DATA} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Word index: drop the byte offset, wrap silently past the top of the array.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADRESS_WIDTH-1:0] a);
    return a[IDX_W+1:2];
  endfunction

  // Address of the beat following 'a' for the given burst attributes.
  function automatic logic [ADRESS_WIDTH-1:0] step_addr(
    input logic [ADRESS_WIDTH-1:0] a,
    input logic [3:0]              len,
    input logic [2:0]              size,
    input logic [1:0]              burst
  );
    logic [2:0]              sz;
    logic [ADRESS_WIDTH-1:0] inc;
    logic [ADRESS_WIDTH-1:0] mask;
    logic [ADRESS_WIDTH-1:0] res;
    sz   = (size > SZ_MAX) ? SZ_MAX : size;
    inc  = {{(ADRESS_WIDTH-1){1'b0}}, 1'b1} << sz;
    mask = ({{(ADRESS_WIDTH-5){1'b0}}, ({1'b0, len} + 5'd1)} << sz) - 1'b1;
    res  = a + inc;
    if (burst == 2'b00) begin
      res = a;
    end else if (burst == 2'b10 &&
                 (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)) begin
      // Stay inside the aligned window of (len+1) beats.
      res = (a & ~mask) | ((a + inc) & mask);
    end
    return res;
  endfunction

  // ---------------------------------------------------------------- write path
  w_state_t                w_state, w_state_nxt;
  logic [ADRESS_WIDTH-1:0] w_addr;
  logic [3:0]              w_len;
  logic [2:0]              w_size;
  logic [1:0]              w_burst;
  logic [3:0]              w_cnt;
  logic                    w_hold;
  logic                    aw_fire, w_fire, w_end;

  assign aw_fire = AWVALID && AWREADY;
  assign w_fire  = WVALID && WREADY;
  assign w_end   = (w_cnt == w_len);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) w_state <= W_IDLE;
    else          w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_fire)         w_state_nxt = W_DATA;
      W_DATA:  if (w_fire && w_end) w_state_nxt = W_IDLE;
      default:                      w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    case (w_state)
      W_IDLE:  AWREADY = 1'b1;
      W_DATA:  WREADY  = !w_hold;
      default: AWREADY = 1'b0;
    endcase
  end

`ifdef AXI_SLV_WAIT_EN
  // One-cycle WREADY gap after each accepted beat.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) w_hold <= 1'b0;
    else          w_hold <= w_fire;
  end
`else
  assign w_hold = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_cnt     <= 4'd0;
      wlast_err <= 1'b0;
    end else begin
      if (aw_fire) w_cnt <= 4'd0;
      else if (w_fire) w_cnt <= w_cnt + 4'd1;
      if (w_fire && (WLAST != w_end)) wlast_err <= 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (aw_fire) begin
      w_addr  <= AWADDR;
      w_len   <= AWLEN;
      w_size  <= AWSIZE;
      w_burst <= AWBURST;
    end else if (w_fire) begin
      w_addr  <= step_addr(w_addr, w_len, w_size, w_burst);
    end
  end

  // Non-blocking write: a read-beat load of the same index this edge sees old data.
  always_ff @(posedge ACLK) begin
    if (w_fire) mem[word_idx(w_addr)] <= WDATA;
  end

  // ----------------------------------------------------------------- read path
  r_state_t                r_state, r_state_nxt;
  logic [ADRESS_WIDTH-1:0] r_addr, r_addr_nxt;
  logic [3:0]              r_len;
  logic [2:0]              r_size;
  logic [1:0]              r_burst;
  logic [3:0]              r_cnt;
  logic [DATA_WIDTH-1:0]   rdata_p1;
  logic                    rlast_p1;
  logic                    ar_fire, r_fire, r_end;

  assign ar_fire    = ARVALID && ARREADY;
  assign r_fire     = RVALID && RREADY;
  assign r_end      = (r_cnt == r_len);
  assign r_addr_nxt = step_addr(r_addr, r_len, r_size, r_burst);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_state <= R_IDLE;
    else          r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire)         r_state_nxt = R_DATA;
      R_DATA:  if (r_fire && r_end) r_state_nxt = R_IDLE;
      default:                      r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    case (r_state)
      R_IDLE:  ARREADY = 1'b1;
      R_DATA:  RVALID  = 1'b1;
      default: ARREADY = 1'b0;
    endcase
  end

  // Read output stage: beat loaded on AR accept or on acceptance of the previous beat.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_cnt    <= 4'd0;
      rdata_p1 <= '0;
      rlast_p1 <= 1'b0;
    end else if (ar_fire) begin
      r_cnt    <= 4'd0;
      rdata_p1 <= mem[word_idx(ARADDR)];
      rlast_p1 <= (ARLEN == 4'd0);
    end else if (r_fire) begin
      if (r_end) begin
        rlast_p1 <= 1'b0;
      end else begin
        r_cnt    <= r_cnt + 4'd1;
        rdata_p1 <= mem[word_idx(r_addr_nxt)];
        rlast_p1 <= ((r_cnt + 4'd1) == r_len);
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ar_fire) begin
      r_addr  <= ARADDR;
      r_len   <= ARLEN;
      r_size  <= ARSIZE;
      r_burst <= ARBURST;
    end else if (r_fire && !r_end) begin
      r_addr  <= r_addr_nxt;
    end
  end

  assign RDATA = rdata_p1;
  assign RLAST = rlast_p1;

endmodule

// File: tb/tb_axi_slave_mem.sv
module tb_axi_slave_mem;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        wlast_err;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] ev [16];

  always #5 ACLK = ~ACLK;

  axi_slave_mem #(.DATA_WIDTH(32), .ADRESS_WIDTH(32), .MEM_DEPTH(256)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .wlast_err(wlast_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Write burst; data beat i = dbase+i, WLAST driven on beat wl_beat.
  task automatic wr_burst(input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [31:0] dbase, input int wl_beat);
    int cyc;
    AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    chk("awready_idle", AWREADY, 1);
    tick();
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      WDATA = dbase + i; WLAST = (i == wl_beat); WVALID = 1'b1;
      cyc = 0;
      while (!WREADY && cyc < 20) begin tick(); cyc++; end
      chk("wready", WREADY, 1);
      tick();
      if (i < int'(len)) chk("awready_mid", AWREADY, 0);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    chk("wready_end", WREADY, 0);
    chk("awready_end", AWREADY, 1);
  endtask

  // Read burst checked against ev[]; RREADY held low stall_n cycles on beat stall_b.
  task automatic rd_burst(input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int stall_b, input int stall_n);
    int cyc;
    ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    RREADY = 1'b1;
    chk("arready_idle", ARREADY, 1);
    tick();
    ARVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      cyc = 0;
      while (!RVALID && cyc < 20) begin tick(); cyc++; end
      chk("rvalid", RVALID, 1);
      if (i > 0) chk("r_nobubble", cyc, 0);
      if (i == stall_b) begin
        RREADY = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          chk("rhold_data", RDATA, ev[i]);
          chk("rhold_valid", RVALID, 1);
        end
        RREADY = 1'b1;
      end
      chk("rdata", RDATA, ev[i]);
      chk("rlast", RLAST, (i == int'(len)));
      tick();
    end
    RREADY = 1'b0;
    chk("rvalid_end", RVALID, 0);
    chk("rlast_end", RLAST, 0);
    chk("arready_end", ARREADY, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ARESETn = 1'b0;
    AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WLAST = 1'b0; WVALID = 1'b0;
    ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
    RREADY = 1'b0;
    #1;
    chk("rst_awready", AWREADY, 1);
    chk("rst_arready", ARREADY, 1);
    chk("rst_wready", WREADY, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_rlast", RLAST, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_wlast_err", wlast_err, 0);
    tick(); tick();
    ARESETn = 1'b1;
    tick();

    // INCR write 100, words 25..28 = 1..4
    wr_burst(32'd100, 4'd3, 3'd2, 2'b01, 32'd1, 3);
    chk("incr_wlast_err", wlast_err, 0);

    // INCR read back, no stall then stall on beat 1
    ev[0] = 1; ev[1] = 2; ev[2] = 3; ev[3] = 4;
    rd_burst(32'd100, 4'd3, 3'd2, 2'b01, -1, 0);
    rd_burst(32'd100, 4'd3, 3'd2, 2'b01, 1, 3);

    // WRAP write at 0x18: beats land at 0x18,0x1C,0x10,0x14
    wr_burst(32'h18, 4'd3, 3'd2, 2'b10, 32'hA0, 3);
    ev[0] = 32'hA2; ev[1] = 32'hA3; ev[2] = 32'hA0; ev[3] = 32'hA1;
    rd_burst(32'h10, 4'd3, 3'd2, 2'b01, -1, 0);
    ev[0] = 32'hA0; ev[1] = 32'hA1; ev[2] = 32'hA2; ev[3] = 32'hA3;
    rd_burst(32'h18, 4'd3, 3'd2, 2'b10, -1, 0);

    // FIXED write: all three beats hit word 16, last one wins; single-beat read
    wr_burst(32'h40, 4'd2, 3'd2, 2'b00, 32'h50, 2);
    ev[0] = 32'h52;
    rd_burst(32'h40, 4'd0, 3'd2, 2'b01, -1, 0);
    ev[0] = 32'h52; ev[1] = 32'h52; ev[2] = 32'h52;
    rd_burst(32'h40, 4'd2, 3'd2, 2'b00, -1, 0);

    // Early WLAST on beat 1: error flagged, burst still 4 beats
    wr_burst(32'h80, 4'd3, 3'd2, 2'b01, 32'h70, 1);
    chk("early_wlast_err", wlast_err, 1);
    ev[0] = 32'h70; ev[1] = 32'h71; ev[2] = 32'h72; ev[3] = 32'h73;
    rd_burst(32'h80, 4'd3, 3'd2, 2'b01, -1, 0);
    wr_burst(32'hC0, 4'd0, 3'd2, 2'b01, 32'h11, 0);
    chk("sticky_wlast_err", wlast_err, 1);

    // Index wraps past top of array: 0x3FC -> word 255, 0x400 -> word 0
    wr_burst(32'h3FC, 4'd1, 3'd2, 2'b01, 32'h90, 1);
    ev[0] = 32'h91;
    rd_burst(32'h0, 4'd0, 3'd2, 2'b01, -1, 0);

    // Reset during beat 2 of a write burst at word 0
    AWADDR = 32'h0; AWLEN = 4'd3; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      WDATA = 32'hC0 + i; WLAST = 1'b0; WVALID = 1'b1;
      for (int c = 0; c < 20 && !WREADY; c++) tick();
      tick();
    end
    WDATA = 32'hC2;
    ARESETn = 1'b0;
    #1;
    chk("midrst_wready", WREADY, 0);
    chk("midrst_awready", AWREADY, 1);
    chk("midrst_wlast_err", wlast_err, 0);
    WVALID = 1'b0;
    tick();
    ARESETn = 1'b1;
    tick();
    ev[0] = 32'hC0; ev[1] = 32'hC1;
    rd_burst(32'h0, 4'd1, 3'd2, 2'b01, -1, 0);
    ev[0] = 32'h90;
    rd_burst(32'h3FC, 4'd0, 3'd2, 2'b01, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
